// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path: geometry and requester IDs.
package regfile_pkg;

    localparam int unsigned DATA_W   = 20;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    // Requester index width; grant_id is always this wide.
    localparam int unsigned REQ_ID_W = 2;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_ALU = 2'd0;
    localparam req_id_t REQ_MEM = 2'd1;
    localparam req_id_t REQ_DBG = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner select from valid + priority pointer,
// with the pointer register advancing past each accepted requester.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = REQ_ID_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    // Search ptr, ptr+1, ... (mod NUM_REQ); first valid requester wins.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // One-hot grant, suppressed entirely when not enabled.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && win_found && (win_idx == IDX_W'(i));
        end
    end

    assign grant_idx = win_idx;

    // Pointer moves to the slot after the accepted requester; holds otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback requesters: round-robin
// arbitration, a registered write stage, and a per-register busy scoreboard.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data,
    output logic [REQ_ID_W-1:0]       grant_id,
    output logic [NUM_REGS-1:0]       busy,
    output logic                      rsv_conflict
);

    logic [REQ_ID_W-1:0] win_idx;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_register_q, write_register_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [REQ_ID_W-1:0] grant_id_q, grant_id_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rsv_conflict_q, rsv_conflict_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_ID_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .enable    (~wb_hold & rst_n),
        .grant     (req_ready),
        .grant_idx (win_idx)
    );

    assign accept = |req_ready;

    // Pick the winner's address and data out of the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == REQ_ID_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: load on acceptance, otherwise drop the enable and hold the rest.
    always_comb begin
        reg_write_d      = accept;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        grant_id_d       = grant_id_q;
        if (accept) begin
            write_register_d = sel_addr;
            write_data_d     = sel_data;
            grant_id_d       = win_idx;
        end
    end

    // Scoreboard: clear on the write edge, then set from reservation (set wins).
    always_comb begin
        logic clearing;
        clearing       = reg_write_q && (write_register_q == rsv_addr);
        busy_d         = busy_q;
        rsv_conflict_d = rsv_valid && busy_q[rsv_addr] && !clearing;
        if (reg_write_q) begin
            busy_d[write_register_q] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // All state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            grant_id_q       <= '0;
            busy_q           <= '0;
            rsv_conflict_q   <= 1'b0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            grant_id_q       <= grant_id_d;
            busy_q           <= busy_d;
            rsv_conflict_q   <= rsv_conflict_d;
        end
    end

    // A write still pending when reset asserts must never reach the register file.
    assign reg_write      = reg_write_q & rst_n;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign grant_id       = grant_id_q;
    assign busy           = busy_q;
    assign rsv_conflict   = rsv_conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: reference model plus a write scoreboard.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int DW = 20;
    localparam int AW = 3;
    localparam int NG = 8;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wb_hold;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              reg_write;
    logic [AW-1:0]     write_register;
    logic [DW-1:0]     write_data;
    logic [1:0]        grant_id;
    logic [NG-1:0]     busy;
    logic              rsv_conflict;

    regfile_write_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NG)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .wb_hold        (wb_hold),
        .rsv_valid      (rsv_valid),
        .rsv_addr       (rsv_addr),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .grant_id       (grant_id),
        .busy           (busy),
        .rsv_conflict   (rsv_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the DUT write port.
    logic [DW-1:0] rf [NG];
    always @(posedge clk) begin
        if (reg_write) rf[write_register] <= write_data;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    id;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int            m_ptr  = 0;
    logic          m_rw   = 1'b0;
    logic [AW-1:0] m_wa   = '0;
    logic [DW-1:0] m_wd   = '0;
    logic [1:0]    m_gid  = '0;
    logic [NG-1:0] m_busy = '0;
    logic          m_conf = 1'b0;

    logic [NR-1:0] last_ready;
    int            last_grant;
    int            grant_log[$];

    // One clock cycle: check ready against the model, push expected writes,
    // then after the edge pop and compare the write port and scoreboard.
    task automatic step(input string tag);
        logic [NR-1:0] exp_ready;
        logic [NG-1:0] nb;
        logic          nc;
        logic          any;
        logic          rst_s;
        int            w;
        exp_t          e;
        #1;
        exp_ready = '0;
        any       = 1'b0;
        w         = 0;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (!any && req_valid[i]) begin
                any = 1'b1;
                w   = i;
            end
        end
        if (any && !wb_hold && rst_n) exp_ready[w] = 1'b1;
        last_ready = req_ready;
        n_checks++;
        if (req_ready !== exp_ready)
            $display("FAIL %s ready: got %b expected %b", tag, req_ready, exp_ready);
        else n_pass++;
        if (exp_ready != '0) begin
            e.a  = req_addr[w*AW +: AW];
            e.d  = req_data[w*DW +: DW];
            e.id = 2'(w);
            sb_q.push_back(e);
            m_ptr      = (w + 1) % NR;
            last_grant = w;
            grant_log.push_back(w);
        end
        nb = m_busy;
        if (m_rw) nb[m_wa] = 1'b0;
        nc = rsv_valid && m_busy[rsv_addr] && !(m_rw && m_wa == rsv_addr);
        if (rsv_valid) nb[rsv_addr] = 1'b1;
        rst_s = rst_n;
        @(posedge clk);
        #1;
        if (!rst_s) begin
            sb_q.delete();
            m_ptr = 0; m_rw = 1'b0; m_wa = '0; m_wd = '0; m_gid = '0;
            m_busy = '0; m_conf = 1'b0;
        end else begin
            m_busy = nb;
            m_conf = nc;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                m_rw = 1'b1; m_wa = e.a; m_wd = e.d; m_gid = e.id;
            end else begin
                m_rw = 1'b0;
            end
        end
        n_checks++;
        if ({reg_write, write_register, write_data, grant_id} !== {m_rw, m_wa, m_wd, m_gid})
            $display("FAIL %s write: got we=%b a=%0d d=%h id=%0d expected we=%b a=%0d d=%h id=%0d",
                     tag, reg_write, write_register, write_data, grant_id,
                     m_rw, m_wa, m_wd, m_gid);
        else n_pass++;
        n_checks++;
        if ({busy, rsv_conflict} !== {m_busy, m_conf})
            $display("FAIL %s scoreboard: got busy=%b conf=%b expected busy=%b conf=%b",
                     tag, busy, rsv_conflict, m_busy, m_conf);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step("reset0");
        step("reset1");
        n_checks++;
        if ({reg_write, write_register, write_data, grant_id, busy, rsv_conflict} !== '0)
            $display("FAIL reset_state: got we=%b a=%0d d=%h id=%0d busy=%b conf=%b required all 0",
                     reg_write, write_register, write_data, grant_id, busy, rsv_conflict);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_only();
        req_valid = 3'b001;
        set_req(0, 3'd5, 20'h0000A);
        step("alu_acc");
        n_checks++;
        if (last_ready !== 3'b001) $display("FAIL alu_ready: got %b required 001", last_ready);
        else n_pass++;
        req_valid = '0;
        n_checks++;
        if ({reg_write, write_register, write_data} !== {1'b1, 3'd5, 20'h0000A})
            $display("FAIL alu_write: got we=%b a=%0d d=%h required we=1 a=5 d=0000a",
                     reg_write, write_register, write_data);
        else n_pass++;
        step("alu_wr");
        n_checks++;
        if (rf[5] !== 20'h0000A) $display("FAIL alu_rf5: got %h required 0000a", rf[5]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int cnt[NR];
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        rst_n = 1'b0;
        step("rr_reset");
        rst_n = 1'b1;
        set_req(0, 3'd1, 20'h11111);
        set_req(1, 3'd2, 20'h22222);
        set_req(2, 3'd4, 20'h44444);
        req_valid = 3'b111;
        grant_log.delete();
        for (int c = 0; c < 6; c++) step("rr");
        req_valid = '0;
        step("rr_drain");
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (c >= grant_log.size()) begin
                $display("FAIL rr_order[%0d]: no grant recorded, required %0d", c, exp_order[c]);
            end else begin
                cnt[grant_log[c]]++;
                if (grant_log[c] !== exp_order[c])
                    $display("FAIL rr_order[%0d]: got %0d required %0d", c, grant_log[c],
                             exp_order[c]);
                else n_pass++;
            end
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (cnt[i] !== 2) $display("FAIL rr_count[%0d]: got %0d required 2", i, cnt[i]);
            else n_pass++;
        end
        n_checks++;
        if (rf[4] !== 20'h44444) $display("FAIL rr_rf4: got %h required 44444", rf[4]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1'b1; rsv_addr = 3'd3;
        step("sb_rsv");
        rsv_valid = 1'b0;
        n_checks++;
        if (busy[3] !== 1'b1) $display("FAIL sb_set: got busy3=%b required 1", busy[3]);
        else n_pass++;
        req_valid = 3'b010;
        set_req(1, 3'd3, 20'h00014);
        step("sb_acc");
        req_valid = '0;
        n_checks++;
        if (busy[3] !== 1'b1) $display("FAIL sb_pending: got busy3=%b required 1", busy[3]);
        else n_pass++;
        step("sb_clr");
        n_checks++;
        if (busy[3] !== 1'b0 || rf[3] !== 20'h00014)
            $display("FAIL sb_clear: got busy3=%b rf3=%h required 0 00014", busy[3], rf[3]);
        else n_pass++;
        // Reserve again, write again, and re-reserve on the clearing edge.
        rsv_valid = 1'b1;
        step("sb_rsv2");
        rsv_valid = 1'b0;
        req_valid = 3'b010;
        set_req(1, 3'd3, 20'h00015);
        step("sb_acc2");
        req_valid = '0;
        rsv_valid = 1'b1;
        step("sb_same_edge");
        rsv_valid = 1'b0;
        n_checks++;
        if (busy[3] !== 1'b1 || rsv_conflict !== 1'b0)
            $display("FAIL sb_set_wins: got busy3=%b conf=%b required 1 0", busy[3], rsv_conflict);
        else n_pass++;
    endtask

    task automatic test_conflict();
        rsv_valid = 1'b1; rsv_addr = 3'd6;
        step("cf_rsv1");
        n_checks++;
        if (rsv_conflict !== 1'b0) $display("FAIL cf_first: got conf=%b required 0", rsv_conflict);
        else n_pass++;
        step("cf_rsv2");
        rsv_valid = 1'b0;
        n_checks++;
        if (busy[6] !== 1'b1 || rsv_conflict !== 1'b1)
            $display("FAIL cf_pulse: got busy6=%b conf=%b required 1 1", busy[6], rsv_conflict);
        else n_pass++;
        step("cf_after");
        n_checks++;
        if (rsv_conflict !== 1'b0) $display("FAIL cf_single: got conf=%b required 0", rsv_conflict);
        else n_pass++;
    endtask

    task automatic test_hold();
        req_valid = 3'b001;
        set_req(0, 3'd0, 20'h0ABCD);
        step("hold_pre");
        req_valid = 3'b101;
        set_req(0, 3'd1, 20'h0A001);
        set_req(2, 3'd2, 20'h0D002);
        wb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step("hold");
            n_checks++;
            if (last_ready !== 3'b000 || reg_write !== 1'b0)
                $display("FAIL hold[%0d]: got ready=%b we=%b required 000 0", c, last_ready,
                         reg_write);
            else n_pass++;
        end
        wb_hold = 1'b0;
        step("hold_rel");
        req_valid = 3'b001;
        n_checks++;
        if (last_ready !== 3'b100)
            $display("FAIL hold_resume: got ready=%b required 100", last_ready);
        else n_pass++;
        step("hold_alu");
        req_valid = '0;
        step("hold_drain");
        n_checks++;
        if (rf[0] !== 20'h0ABCD) $display("FAIL hold_rf0: got %h required 0abcd", rf[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b001;
        set_req(0, 3'd5, 20'h00055);
        rsv_valid = 1'b1; rsv_addr = 3'd1;
        step("rm_acc");
        req_valid = '0;
        rsv_valid = 1'b0;
        rst_n = 1'b0;
        step("rm_reset");
        n_checks++;
        if (reg_write !== 1'b0 || busy !== '0 || rf[5] !== 20'h0000A)
            $display("FAIL rm_drop: got we=%b busy=%b rf5=%h required 0 0 0000a",
                     reg_write, busy, rf[5]);
        else n_pass++;
        rst_n = 1'b1;
        req_valid = 3'b111;
        step("rm_ptr");
        req_valid = '0;
        n_checks++;
        if (last_ready !== 3'b001) $display("FAIL rm_ptr0: got ready=%b required 001", last_ready);
        else n_pass++;
        step("rm_drain");
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        wb_hold   = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        @(negedge clk);
        test_reset();
        test_alu_only();
        test_round_robin();
        test_scoreboard();
        test_conflict();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
